// File: rtl/gps_capture_logger.sv
// gps_capture_logger: BRAM sample capture buffer for GPS/SDR debug.
// Two capture modes: one-shot fill-until-full, or circular pre-trigger where a
// trigger freezes the buffer after post_cnt further samples. The CPU reads the
// frozen buffer one word per rd strobe, starting at the oldest sample.
// Optional build macro: LOGGER_DECIM_EN (accept one wr out of every decim+1).
module gps_capture_logger #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          mode,
  input  logic          trig,
  input  logic [AW-1:0] post_cnt,
  input  logic [7:0]    decim,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd_rst,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

  // state | meaning
  // IDLE  | no capture since reset; buffer readable
  // FILL  | one-shot capture, stops after DEPTH words
  // PRE   | circular capture, waiting for trigger
  // POST  | trigger seen, storing remaining post-trigger words
  // DONE  | capture complete, buffer frozen and readable
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PRE, S_POST, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic [AW:0]   level_q, level_d;
  logic          wrapped_q, wrapped_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [DW-1:0] mem [DEPTH];

  logic capturing;
  logic dec_ok;
  logic wr_acc;

  assign capturing = (state_q == S_FILL) || (state_q == S_PRE) || (state_q == S_POST);

`ifdef LOGGER_DECIM_EN
  logic [7:0] dcnt_q, dcnt_d;

  // Decimation phase: a wr is accepted only when the phase counter is at zero.
  always_comb begin
    dcnt_d = dcnt_q;
    dec_ok = (dcnt_q == 8'd0);
    if (arm) begin
      dcnt_d = 8'd0;
    end else if (wr && capturing) begin
      dcnt_d = (dcnt_q >= decim) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  // Decimation phase register.
  always_ff @(posedge clk) begin
    if (rst) dcnt_q <= 8'd0;
    else     dcnt_q <= dcnt_d;
  end
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign dec_ok = 1'b1;
`endif

  // arm in the same cycle restarts everything, so the write is dropped.
  assign wr_acc = wr && capturing && dec_ok && !arm;

  // Next-state, pointer, level and read-address computation.
  always_comb begin
    logic go_done;
    state_d      = state_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    start_addr_d = start_addr_q;
    remaining_d  = remaining_q;
    level_d      = level_q;
    wrapped_d    = wrapped_q;
    busy_d       = busy_q;
    done_d       = done_q;
    go_done      = 1'b0;

    if (arm) begin
      state_d      = mode ? S_PRE : S_FILL;
      waddr_d      = '0;
      raddr_d      = '0;
      start_addr_d = '0;
      remaining_d  = '0;
      level_d      = '0;
      wrapped_d    = 1'b0;
      busy_d       = 1'b1;
      done_d       = 1'b0;
    end else begin
      if (wr_acc) begin
        waddr_d = waddr_q + AW'(1);
        if (level_q != LEVEL_MAX) level_d = level_q + (AW+1)'(1);
      end

      unique case (state_q)
        S_FILL: begin
          if (wr_acc && (waddr_q == {AW{1'b1}})) go_done = 1'b1;
        end
        S_PRE: begin
          if (wr_acc && (waddr_q == {AW{1'b1}})) wrapped_d = 1'b1;
          if (trig) begin
            if (post_cnt == '0) begin
              go_done = 1'b1;
            end else begin
              state_d     = S_POST;
              remaining_d = post_cnt;
            end
          end
        end
        S_POST: begin
          if (wr_acc) begin
            if (waddr_q == {AW{1'b1}}) wrapped_d = 1'b1;
            remaining_d = remaining_q - AW'(1);
            if (remaining_q == AW'(1)) go_done = 1'b1;
          end
        end
        S_IDLE, S_DONE: begin
          if (rd_rst)  raddr_d = start_addr_q;
          else if (rd) raddr_d = raddr_q + AW'(1);
        end
        default: state_d = S_IDLE;
      endcase

      // Oldest word sits at the next write address once the buffer has wrapped.
      if (go_done) begin
        state_d      = S_DONE;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        start_addr_d = wrapped_d ? waddr_d : '0;
      end
    end

    dout_d = mem[raddr_d];
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      waddr_q      <= '0;
      raddr_q      <= '0;
      start_addr_q <= '0;
      remaining_q  <= '0;
      level_q      <= '0;
      wrapped_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      start_addr_q <= start_addr_d;
      remaining_q  <= remaining_d;
      level_q      <= level_d;
      wrapped_q    <= wrapped_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[waddr_q] <= din;
  end

  assign dout  = dout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign level = level_q;

endmodule

// File: tb/tb_gps_capture_logger.sv
// Scoreboard bench for gps_capture_logger: stimulus pushes expected values,
// monitors pop and compare on status strobes and on read-data arrival.
module tb_gps_capture_logger;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          mode = 1'b0;
  logic          trig = 1'b0;
  logic [AW-1:0] post_cnt = '0;
  logic [7:0]    decim = '0;
  logic          wr = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_rst = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] dout;
  logic          busy;
  logic          done;
  logic [AW:0]   level;

  gps_capture_logger #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode), .trig(trig),
    .post_cnt(post_cnt), .decim(decim), .wr(wr), .din(din),
    .rd_rst(rd_rst), .rd(rd), .dout(dout), .busy(busy), .done(done),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } chk_t;

  localparam int SIG_BUSY  = 0;
  localparam int SIG_DONE  = 1;
  localparam int SIG_LEVEL = 2;
  localparam int SIG_DOUT  = 3;

  chk_t st_q[$];
  int   rd_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic st_go = 1'b0;
  logic rd_seen = 1'b0;
  chk_t mon_c;
  int   mon_act;

  task automatic compare(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Read data is presented one clock after an rd or rd_rst strobe.
  always @(posedge clk) rd_seen <= rd | rd_rst;

  always @(negedge clk) begin
    if (st_go) begin
      while (st_q.size() > 0) begin
        mon_c = st_q.pop_front();
        case (mon_c.sig)
          SIG_BUSY:  mon_act = int'(busy);
          SIG_DONE:  mon_act = int'(done);
          SIG_LEVEL: mon_act = int'(level);
          default:   mon_act = int'(dout);
        endcase
        compare(mon_c.name, mon_act, mon_c.exp);
      end
    end
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL readback: data %0d arrived with no expected value queued", dout);
      end else begin
        compare("readback", int'(dout), rd_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string name, input int sig, input int exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    st_q.push_back(c);
  endtask

  task automatic expect_status(input string name, input int b, input int d, input int l);
    expect_st({name, "_busy"}, SIG_BUSY, b);
    expect_st({name, "_done"}, SIG_DONE, d);
    expect_st({name, "_level"}, SIG_LEVEL, l);
  endtask

  task automatic check_now();
    st_go = 1'b1;
    tick();
    st_go = 1'b0;
  endtask

  task automatic do_arm(input logic m);
    arm  = 1'b1;
    mode = m;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_trig(input logic [AW-1:0] p, input logic w, input logic [DW-1:0] d);
    trig     = 1'b1;
    post_cnt = p;
    wr       = w;
    din      = d;
    tick();
    trig = 1'b0;
    wr   = 1'b0;
  endtask

  task automatic write_burst(input int first, input int n, input int step);
    for (int k = 0; k < n; k++) begin
      wr  = 1'b1;
      din = DW'(first + k * step);
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic rb_start(input int exp);
    rd_q.push_back(exp);
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
  endtask

  task automatic rb_next(input int exp);
    rd_q.push_back(exp);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic readback(input int first, input int n, input int step);
    rb_start(first);
    for (int k = 1; k < n; k++) begin
      rd_q.push_back(first + k * step);
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
  endtask

  initial begin
    // Reset values, sampled while reset is still asserted.
    repeat (3) tick();
    expect_status("reset", 0, 0, 0);
    expect_st("reset_dout", SIG_DOUT, 0);
    check_now();
    rst = 1'b0;
    tick();

    // One-shot fill: done exactly at the 1024th write, later writes dropped.
    do_arm(1'b0);
    write_burst(0, 1023, 1);
    expect_status("fill_1023", 1, 0, 1023);
    check_now();
    write_burst(1023, 1, 1);
    expect_status("fill_full", 0, 1, 1024);
    check_now();
    write_burst(1024, 6, 1);
    expect_status("fill_after", 0, 1, 1024);
    check_now();
    readback(0, 1024, 1);

    // Circular pre-trigger with wrap: oldest word at 1600 mod 1024 = 576.
    do_arm(1'b1);
    write_burst(0, 1500, 1);
    expect_status("pre_wrapped", 1, 0, 1024);
    check_now();
    do_trig(10'd100, 1'b0, '0);
    write_burst(1500, 99, 1);
    expect_status("post_99", 1, 0, 1024);
    check_now();
    write_burst(1599, 1, 1);
    expect_status("post_done", 0, 1, 1024);
    check_now();
    write_burst(1600, 100, 1);
    readback(576, 1024, 1);

    // Trigger before wrap: oldest word at address 0.
    do_arm(1'b1);
    write_burst(0, 10, 1);
    do_trig(10'd5, 1'b0, '0);
    write_burst(10, 5, 1);
    expect_status("nowrap", 0, 1, 15);
    check_now();
    readback(0, 15, 1);

    // post_cnt = 0 with a coincident write: done next cycle, write kept.
    do_arm(1'b1);
    write_burst(100, 3, 1);
    do_trig(10'd0, 1'b1, 16'd103);
    expect_status("post0", 0, 1, 4);
    check_now();
    write_burst(104, 2, 1);
    expect_status("post0_after", 0, 1, 4);
    check_now();
    readback(100, 4, 1);
    rb_next(4);

    // arm and trig together in PRE: arm wins, trig dropped.
    do_arm(1'b1);
    write_burst(0, 5, 1);
    arm      = 1'b1;
    trig     = 1'b1;
    mode     = 1'b1;
    post_cnt = '0;
    tick();
    arm  = 1'b0;
    trig = 1'b0;
    expect_status("collide", 1, 0, 0);
    check_now();
    write_burst(7, 1, 1);
    expect_status("collide_pre", 1, 0, 1);
    check_now();

    // Reset during POST aborts to IDLE.
    do_arm(1'b1);
    write_burst(0, 5, 1);
    do_trig(10'd10, 1'b0, '0);
    write_burst(5, 2, 1);
    expect_status("in_post", 1, 0, 7);
    check_now();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_status("post_rst", 0, 0, 0);
    check_now();

    // Re-arm during FILL: level restarts and next write lands at address 0.
    do_arm(1'b0);
    write_burst(0, 300, 1);
    expect_status("fill_300", 1, 0, 300);
    check_now();
    do_arm(1'b0);
    expect_status("rearm", 1, 0, 0);
    check_now();
    write_burst(16'hBEEF, 1, 0);
    write_burst(1, 1023, 1);
    expect_status("rearm_full", 0, 1, 1024);
    check_now();
    rb_start(16'hBEEF);
    rb_next(1);
    rb_next(2);

    // Decimated one-shot capture.
    decim = 8'd3;
    do_arm(1'b0);
    write_burst(0, 4096, 1);
    expect_status("decim", 0, 1, 1024);
    check_now();
`ifdef LOGGER_DECIM_EN
    readback(0, 1024, 4);
`else
    readback(0, 1024, 1);
`endif

    repeat (3) tick();
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      $display("FAIL drain: %0d status and %0d read checks never compared",
               st_q.size(), rd_q.size());
      n_checks = n_checks + st_q.size() + rd_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gps_capture_logger.md
Name: gps_capture_logger

Overview:
- Parametrised IQ/sample capture buffer for GPS and SDR debug.
- Block RAM of 2^AW words x DW bits, filled from the sample stream and read back by the embedded CPU one word per read strobe.
- Two capture modes:
  - one-shot fill-until-full;
  - circular pre-trigger, where a trigger pulse freezes the buffer after a programmable number of post-trigger samples.
- Sits between the sample source and the CPU command/response register path.

Parameters:
DW, 16, sample/word width in bits
AW, 10, address width; DEPTH = 2^AW words

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
arm  in  1  single-cycle pulse; clears pointers and starts capture
mode  in  1  0 = one-shot, 1 = circular pre-trigger; sampled on arm
trig  in  1  single-cycle trigger pulse (circular mode only)
post_cnt  in  AW  post-trigger sample count; sampled when trig is accepted
decim  in  8  decimation ratio minus 1; used only with LOGGER_DECIM_EN
wr  in  1  sample valid strobe
din  in  DW  sample data
rd_rst  in  1  load the read pointer with the oldest-sample address
rd  in  1  advance the read pointer by one
dout  out  DW  word at the read pointer, registered
busy  out  1  capture in progress (PRE or POST or FILL)
done  out  1  capture complete; buffer frozen
level  out  AW+1  valid words in buffer, saturating at DEPTH

Behaviour:
- Reset: state IDLE; waddr, raddr, start_addr and level cleared; wrapped flag cleared; busy=0, done=0. dout=0 after reset. BRAM contents are not cleared.
- States and transitions:
  - IDLE -> FILL on arm when mode=0.
  - IDLE -> PRE on arm when mode=1.
  - An arm pulse in any state restarts from address 0 with level=0. This includes DONE and mid-capture.
- Accepted write: wr=1 in FILL, PRE or POST (after decimation, if enabled). It writes din at waddr, then waddr <= waddr+1 mod DEPTH, and level increments, saturating at DEPTH.
- FILL:
  - On the accepted write at waddr = DEPTH-1, go to DONE.
  - Exactly DEPTH words are stored and waddr does not advance further; start_addr = 0.
  - trig is ignored.
- PRE:
  - Writes wrap continuously. On wrap, the wrapped flag is set and level holds at DEPTH.
  - On trig, latch post_cnt into remaining. If post_cnt = 0, go to DONE on the next cycle. Otherwise go to POST.
  - A wr coinciding with trig is accepted and counts as pre-trigger.
- POST:
  - Each accepted write decrements remaining; after the write that makes remaining 0, go to DONE.
  - Further trig pulses are ignored.
- Entering DONE: start_addr = wrapped ? waddr (oldest word) : 0.
- DONE: all writes are ignored.
- arm and trig in the same cycle: arm wins and trig is dropped.
- Read side:
  - rd_rst: raddr <= start_addr.
  - rd: raddr <= raddr+1 mod DEPTH.
  - The BRAM read port is addressed with next-raddr (raddr + rd, or start_addr on rd_rst), so dout shows the new word one clock after the strobe.
  - rd and rd_rst are honoured only in IDLE or DONE; they are ignored while busy.
  - rd_rst and rd in the same cycle: rd_rst wins.
- Reset mid-capture aborts immediately to IDLE.

Optional Feature:
- Macro LOGGER_DECIM_EN.
- Defined:
  - An 8-bit counter accepts one wr out of every decim+1. The counter clears on arm and counts only wr cycles.
  - decim = 0 gives every sample.
  - trig acceptance is not decimated.
- Undefined:
  - decim is ignored, every wr is accepted, and no counter logic is built.

Test Plan:
- One-shot fill: arm with mode=0, then 1030 wr with din = index. Required: done after the 1024th write; level=1024; rd_rst then 1024 rd returns 0..1023; writes 1024..1029 are not stored.
- Circular pre-trigger: arm with mode=1, 1500 writes (din = index), trig with post_cnt=100, then 200 more writes. Required: done after write 1599; start_addr = 1600 mod 1024 = 576; readback yields 576..1599 in order.
- Trigger before wrap: arm with mode=1, 10 writes, trig with post_cnt=5, 5 writes. Required: done, level=15, start_addr=0, readback 0..14.
- post_cnt=0 and arm/trig collision: trig with post_cnt=0 gives done on the next cycle with no further writes stored. Separately, arm and trig in the same cycle in PRE: state stays PRE and level=0.
- Reset and re-arm mid-capture: rst during POST gives IDLE with busy=0, done=0, level=0. Re-arm during FILL at level=300 restarts with level=0, and the next write lands at address 0.
- LOGGER_DECIM_EN: decim=3 with 4096 wr in one-shot mode. Required: done with 1024 words stored, values 0,4,8,...,4092. Build without the macro gives 0..1023.
